// File: rtl/seg_pkg.sv
// Shared widths, scan-state encoding and idle patterns for the 7-segment digit scanner.
package seg_pkg;

    localparam int SEG_W = 7;
    localparam int AN_W  = 8;
    localparam int NIB_W = 4;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

    localparam logic [AN_W-1:0]  AN_ALL_OFF  = 8'hFF;
    localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'h7F;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [AN_W-1:0] an_select(input logic [2:0] idx);
        return ~(AN_W'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Per-digit slot counter; flags the last blanking cycle and the last cycle of the slot.
module seg_refresh_timer #(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic blank_done,
    output logic last
);

    localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign last       = (cnt_q == CW'(DWELL_CYCLES - 1));
    assign blank_done = (cnt_q == CW'(BLANK_CYCLES - 1));

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed 8-digit 7-segment scanner with tear-free frame commit.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      VALUE,
    input  logic             LOAD,
    input  logic [AN_W-1:0]  DP_IN,
    input  logic [AN_W-1:0]  DIGIT_EN,
    output logic [NIB_W-1:0] NIBBLE,
    input  logic [SEG_W-1:0] SEG_IN,
    output logic [SEG_W-1:0] SEG_N,
    output logic             DP_N,
    output logic [AN_W-1:0]  AN_N,
    output logic             FRAME_START
);

    scan_state_t     state_q;
    logic [2:0]      idx_q;
    logic [31:0]     shadow_q;
    logic [AN_W-1:0] shadow_dp_q;
    logic [31:0]     pend_val_q;
    logic [AN_W-1:0] pend_dp_q;
    logic            pend_q;
    logic            started_q;
    logic [AN_W-1:0] an_n_q;
    logic [SEG_W-1:0] seg_n_q;
    logic            dp_n_q;
    logic            frame_start_q;

    logic            blank_done;
    logic            last;
    logic            wrap;
    logic [AN_W-1:0] valid_mask;
    logic [AN_W-1:0] lz_blank;
    logic [AN_W-1:0] digit_on;

    seg_refresh_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .blank_done (blank_done),
        .last       (last)
    );

    assign wrap   = last && (idx_q == 3'(NUM_DIGITS - 1));
    assign NIBBLE = shadow_q[{idx_q, 2'b00} +: NIB_W];

    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < AN_W; i++) begin
            valid_mask[i] = (i < int'(NUM_DIGITS));
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit blanks while everything above it is zero with no DP.
    logic zero_run;
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = AN_W - 1; i >= 0; i--) begin
            if (i < int'(NUM_DIGITS)) begin
                zero_run = zero_run && (shadow_q[4*i +: NIB_W] == '0) && !shadow_dp_q[i];
                if (i > 0) begin
                    lz_blank[i] = zero_run;
                end
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign digit_on = DIGIT_EN & valid_mask & ~lz_blank;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            an_n_q        <= AN_ALL_OFF;
            seg_n_q       <= SEG_ALL_OFF;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
            started_q     <= 1'b0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_q        <= 1'b0;
        end else begin
            seg_n_q       <= ~SEG_IN;
            dp_n_q        <= ~(shadow_dp_q[idx_q] & digit_on[idx_q]);
            frame_start_q <= wrap | ~started_q;
            started_q     <= 1'b1;

            unique case (state_q)
                ST_BLANK: begin
                    if (blank_done) begin
                        state_q <= ST_SHOW;
                        an_n_q  <= digit_on[idx_q] ? an_select(idx_q) : AN_ALL_OFF;
                    end
                end
                ST_SHOW: begin
                    if (last) begin
                        state_q <= ST_BLANK;
                        an_n_q  <= AN_ALL_OFF;
                        idx_q   <= wrap ? 3'd0 : idx_q + 3'd1;
                    end else begin
                        an_n_q  <= digit_on[idx_q] ? an_select(idx_q) : AN_ALL_OFF;
                    end
                end
                default: state_q <= ST_BLANK;
            endcase

            // A LOAD coinciding with the commit bypasses pending and lands in the shadow directly.
            if (wrap) begin
                pend_q <= 1'b0;
                if (LOAD) begin
                    shadow_q    <= VALUE;
                    shadow_dp_q <= DP_IN;
                end else if (pend_q) begin
                    shadow_q    <= pend_val_q;
                    shadow_dp_q <= pend_dp_q;
                end
            end else if (LOAD) begin
                pend_val_q <= VALUE;
                pend_dp_q  <= DP_IN;
                pend_q     <= 1'b1;
            end
        end
    end

    assign AN_N        = an_n_q;
    assign SEG_N       = seg_n_q;
    assign DP_N        = dp_n_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner (8-cycle slots, 2 blanking cycles, 8 digits);
// honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_digit_scanner;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] VALUE;
    logic        LOAD;
    logic [7:0]  DP_IN;
    logic [7:0]  DIGIT_EN;
    logic [3:0]  NIBBLE;
    logic [6:0]  SEG_IN;
    logic [6:0]  SEG_N;
    logic        DP_N;
    logic [7:0]  AN_N;
    logic        FRAME_START;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    int          lq_k[$];
    logic [31:0] lq_v[$];
    logic [7:0]  lq_d[$];

    seg_digit_scanner #(
        .NUM_DIGITS   (8),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .VALUE       (VALUE),
        .LOAD        (LOAD),
        .DP_IN       (DP_IN),
        .DIGIT_EN    (DIGIT_EN),
        .NIBBLE      (NIBBLE),
        .SEG_IN      (SEG_IN),
        .SEG_N       (SEG_N),
        .DP_N        (DP_N),
        .AN_N        (AN_N),
        .FRAME_START (FRAME_START)
    );

    always #5 CLK = ~CLK;

    // External hex-to-segment decoder, active-high, bit0 = segment a.
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    assign SEG_IN = seg_lut(NIBBLE);

    function automatic logic [7:0] vis_mask(input logic [31:0] w, input logic [7:0] dp,
                                            input logic [7:0] en);
        logic [7:0] m;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic run;
`endif
        m = en;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        run = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            run = run && (w[4*i +: 4] == 4'h0) && !dp[i];
            if (i > 0 && run) m[i] = 1'b0;
        end
`endif
        return m;
    endfunction

    task automatic check(input string tag, input int kk, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, kk, obs, exp);
        end
    endtask

    task automatic queue_load(input int at_k, input logic [31:0] v, input logic [7:0] d);
        lq_k.push_back(at_k);
        lq_v.push_back(v);
        lq_d.push_back(d);
    endtask

    // Run edges until k reaches stop_k, checking outputs against the expected shadow word.
    task automatic run_until(input int stop_k, input logic [31:0] w, input logic [7:0] dp,
                             input logic [7:0] en);
        logic [7:0] vis;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         cnt;
        int         idx;
        DIGIT_EN = en;
        vis = vis_mask(w, dp, en);
        while (k < stop_k) begin
            if (lq_k.size() > 0 && lq_k[0] == k + 1) begin
                LOAD  = 1'b1;
                VALUE = lq_v[0];
                DP_IN = lq_d[0];
                void'(lq_k.pop_front());
                void'(lq_v.pop_front());
                void'(lq_d.pop_front());
            end else begin
                LOAD = 1'b0;
            end
            @(posedge CLK);
            #1;
            k++;
            cnt = k % 8;
            idx = (k / 8) % 8;
            exp_an = (cnt >= 2 && vis[idx]) ? ~(8'h01 << idx) : 8'hFF;
            check("an_n", k, {24'h0, AN_N}, {24'h0, exp_an});
            check("frame_start", k, {31'h0, FRAME_START}, {31'h0, (k == 1 || k % 64 == 0)});
            check("nibble", k, {28'h0, NIBBLE}, {28'h0, w[4*idx +: 4]});
            if (cnt >= 1) begin
                exp_seg = ~seg_lut(w[4*idx +: 4]);
                exp_dp  = ~(dp[idx] & vis[idx]);
                check("seg_n", k, {25'h0, SEG_N}, {25'h0, exp_seg});
                check("dp_n", k, {31'h0, DP_N}, {31'h0, exp_dp});
            end
        end
        LOAD = 1'b0;
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        LOAD = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_an_n", k, {24'h0, AN_N}, 32'hFF);
        check("rst_seg_n", k, {25'h0, SEG_N}, 32'h7F);
        check("rst_dp_n", k, {31'h0, DP_N}, 32'h1);
        check("rst_nibble", k, {28'h0, NIBBLE}, 32'h0);
        check("rst_frame_start", k, {31'h0, FRAME_START}, 32'h0);
        RST = 1'b0;
        k   = 0;
    endtask

    initial begin
        RST      = 1'b1;
        VALUE    = 32'h0;
        LOAD     = 1'b0;
        DP_IN    = 8'h00;
        DIGIT_EN = 8'hFF;
        @(posedge CLK);
        #1;
        do_reset();

        // Blank frame; back-to-back loads mid-frame, last one must win at the next commit.
        queue_load(30, 32'hDEAD_BEEF, 8'h00);
        queue_load(31, 32'h0123_4567, 8'h00);
        run_until(63, 32'h0, 8'h00, 8'hFF);

        // Pending word with DP on digit 0, committed at the next wrap.
        queue_load(100, 32'h8765_4321, 8'h01);
        run_until(127, 32'h0123_4567, 8'h00, 8'hFF);

        // Lower four digits disabled; pending 1111_1111 is overridden by a LOAD on the commit edge.
        queue_load(150, 32'h1111_1111, 8'h00);
        queue_load(192, 32'hFFFF_FFFF, 8'h00);
        run_until(191, 32'h8765_4321, 8'h01, 8'hF0);
        run_until(255, 32'hFFFF_FFFF, 8'h00, 8'hFF);

        // Pending was cleared, so this frame stays all 'F'; reset lands during digit 5's SHOW.
        run_until(299, 32'hFFFF_FFFF, 8'h00, 8'hFF);
        do_reset();

        queue_load(20, 32'h0000_00A5, 8'h00);
        run_until(63, 32'h0, 8'h00, 8'hFF);
        run_until(127, 32'h0000_00A5, 8'h00, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
